frame_builder: RTL and testbench

- Transmit-side counterpart of the hub's receive frame parser.
- Accepts a destination MAC, source MAC, EtherType and a byte-stream payload. Serialises a complete Ethernet II frame onto a per-port 8-bit transmit stream: preamble, SFD, header, payload, pad, CRC-32 FCS, inter-frame gap.
- Sits between hub forwarding logic and each port's transmit side, one instance per port.

---
 rtl/frame_builder.sv | 239 +++++++++++++++++++++++
 tb/tb_frame_builder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_builder.sv
// rtl/frame_builder.sv - Ethernet II transmit frame serialiser
// Emits preamble, SFD, header, payload, zero pad and CRC-32 FCS, then holds off for the IFG.
module frame_builder #(
  parameter int MIN_PAYLOAD = 46,
  parameter int MAX_PAYLOAD = 1500,
  parameter int IFG_BYTES   = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [47:0] dest_mac,
  input  logic [47:0] src_mac,
  input  logic [15:0] eth_type,
  input  logic [7:0]  pl_data,
  input  logic        pl_valid,
  input  logic        pl_last,
  output logic        pl_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done,
  output logic        trunc_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_DEST, S_SRC, S_TYPE,
    S_PAYLOAD, S_DRAIN, S_PAD, S_FCS, S_IFG
  } state_e;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  state_e       state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [10:0]  pcnt_q, pcnt_d;
  logic [111:0] hdr_q, hdr_d;
  logic [31:0]  crc_q, crc_d;
  logic [7:0]   tx_data_q, tx_data_d;
  logic         tx_valid_q, tx_valid_d;
  logic         crc_en_q, crc_en_d;
  logic         last_q, last_d;
  logic         trunc_q, trunc_d;

  logic         ld, xfer;
  logic [31:0]  crc_nxt, fcs;
  logic [10:0]  pcnt_inc;

  assign ld       = !tx_valid_q || tx_ready;
  assign xfer     = tx_valid_q && tx_ready;
  // The CRC must already include the byte leaving this cycle when FCS byte 0 is loaded.
  assign crc_nxt  = (xfer && crc_en_q) ? crc_byte(crc_q, tx_data_q) : crc_q;
  assign fcs      = ~crc_nxt;
  assign pcnt_inc = pcnt_q + 11'd1;

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = xfer && last_q;
  assign trunc_err = done && trunc_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pcnt_d     = pcnt_q;
    hdr_d      = hdr_q;
    crc_d      = crc_nxt;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    crc_en_d   = crc_en_q;
    last_d     = last_q;
    trunc_d    = trunc_q;
    pl_ready   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          hdr_d      = {dest_mac, src_mac, eth_type};
          crc_d      = 32'hFFFF_FFFF;
          pcnt_d     = '0;
          trunc_d    = 1'b0;
          tx_data_d  = 8'h55;
          tx_valid_d = 1'b1;
          crc_en_d   = 1'b0;
          last_d     = 1'b0;
          cnt_d      = 8'd1;
          state_d    = S_PREAMBLE;
        end
      end
      S_PREAMBLE: begin
        if (ld) begin
          tx_data_d  = 8'h55;
          tx_valid_d = 1'b1;
          if (cnt_q == 8'd6) begin
            cnt_d   = '0;
            state_d = S_SFD;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_SFD: begin
        if (ld) begin
          tx_data_d  = 8'hD5;
          tx_valid_d = 1'b1;
          state_d    = S_DEST;
        end
      end
      S_DEST, S_SRC, S_TYPE: begin
        if (ld) begin
          tx_data_d  = hdr_q[111:104];
          hdr_d      = hdr_q << 8;
          tx_valid_d = 1'b1;
          crc_en_d   = 1'b1;
          cnt_d      = cnt_q + 8'd1;
          if (state_q == S_DEST && cnt_q == 8'd5) begin
            cnt_d   = '0;
            state_d = S_SRC;
          end else if (state_q == S_SRC && cnt_q == 8'd5) begin
            cnt_d   = '0;
            state_d = S_TYPE;
          end else if (state_q == S_TYPE && cnt_q == 8'd1) begin
            cnt_d   = '0;
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        pl_ready = ld && (pcnt_q < 11'(MAX_PAYLOAD));
        if (ld) begin
          if (pl_valid && pcnt_q < 11'(MAX_PAYLOAD)) begin
            tx_data_d  = pl_data;
            tx_valid_d = 1'b1;
            crc_en_d   = 1'b1;
            pcnt_d     = pcnt_inc;
            if (pl_last) begin
              cnt_d   = '0;
              state_d = (pcnt_inc < 11'(MIN_PAYLOAD)) ? S_PAD : S_FCS;
            end else if (pcnt_inc == 11'(MAX_PAYLOAD)) begin
              trunc_d = 1'b1;
              state_d = S_DRAIN;
            end
          end else begin
            tx_valid_d = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        // The final kept byte may still be stalled in the output register.
        pl_ready = 1'b1;
        if (ld) tx_valid_d = 1'b0;
        if (pl_valid && pl_last) begin
          cnt_d   = '0;
          state_d = S_FCS;
        end
      end
      S_PAD: begin
        if (ld) begin
          tx_data_d  = 8'h00;
          tx_valid_d = 1'b1;
          crc_en_d   = 1'b1;
          pcnt_d     = pcnt_inc;
          if (pcnt_inc >= 11'(MIN_PAYLOAD)) begin
            cnt_d   = '0;
            state_d = S_FCS;
          end
        end
      end
      S_FCS: begin
        if (ld) begin
          case (cnt_q[1:0])
            2'd0:    tx_data_d = fcs[7:0];
            2'd1:    tx_data_d = fcs[15:8];
            2'd2:    tx_data_d = fcs[23:16];
            default: tx_data_d = fcs[31:24];
          endcase
          tx_valid_d = 1'b1;
          crc_en_d   = 1'b0;
          last_d     = (cnt_q == 8'd3);
          if (cnt_q == 8'd3) begin
            cnt_d   = '0;
            state_d = S_IFG;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_IFG: begin
        if (ld) begin
          tx_valid_d = 1'b0;
          last_d     = 1'b0;
        end
        // Idle cycles count only once the last FCS byte has left; the IDLE cycle is the final gap byte.
        if (!tx_valid_q) begin
          if (cnt_q == 8'(IFG_BYTES - 2)) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pcnt_q     <= '0;
      hdr_q      <= '0;
      crc_q      <= 32'hFFFF_FFFF;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      crc_en_q   <= 1'b0;
      last_q     <= 1'b0;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pcnt_q     <= pcnt_d;
      hdr_q      <= hdr_d;
      crc_q      <= crc_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      crc_en_q   <= crc_en_d;
      last_q     <= last_d;
      trunc_q    <= trunc_d;
    end
  end

endmodule

// File: tb/tb_frame_builder.sv
// tb/tb_frame_builder.sv - directed self-checking bench for frame_builder
module tb_frame_builder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [47:0] dest_mac = '0;
  logic [47:0] src_mac = '0;
  logic [15:0] eth_type = '0;
  logic [7:0]  pl_data = '0;
  logic        pl_valid = 1'b0;
  logic        pl_last = 1'b0;
  logic        tx_ready = 1'b1;
  logic        pl_ready, tx_valid, busy, done, trunc_err;
  logic [7:0]  tx_data;

  frame_builder dut (
    .clk(clk), .reset(reset), .start(start),
    .dest_mac(dest_mac), .src_mac(src_mac), .eth_type(eth_type),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_last(pl_last), .pl_ready(pl_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .trunc_err(trunc_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc32_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  logic [7:0] pl_mem [0:1535];
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int  cyc = 0, done_n = 0, done_idx = 0, done_cyc = 0, fall_cyc = 0;
  int  trunc_n = 0, ifg_viol = 0, stab_err = 0;
  bit  trunc_at_done = 0, in_ifg = 0, stall_pend = 0, busy_prev = 0, stall_en = 0;
  logic [7:0] held = '0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (in_ifg && tx_valid) ifg_viol++;
    if (busy_prev && !busy) begin
      fall_cyc = cyc;
      in_ifg   = 0;
    end
    busy_prev = busy;
    if (stall_pend && !(tx_valid === 1'b1 && tx_data === held)) stab_err++;
    stall_pend = tx_valid && !tx_ready && !reset;
    held = tx_data;
    if (trunc_err) trunc_n++;
    if (tx_valid && tx_ready) begin
      got.push_back(tx_data);
      if (done) begin
        done_n++;
        done_idx      = got.size();
        done_cyc      = cyc;
        trunc_at_done = trunc_err;
        in_ifg        = 1;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    tx_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic build_exp(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t, input int n);
    int np;
    logic [31:0] c;
    exp_q.delete();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < 6; i++) exp_q.push_back(d[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) exp_q.push_back(s[47-8*i -: 8]);
    exp_q.push_back(t[15:8]);
    exp_q.push_back(t[7:0]);
    np = (n > 1500) ? 1500 : n;
    for (int i = 0; i < np; i++) exp_q.push_back(pl_mem[i]);
    for (int i = np; i < 46; i++) exp_q.push_back(8'h00);
    c = 32'hFFFF_FFFF;
    for (int i = 8; i < exp_q.size(); i++) c = crc32_step(c, exp_q[i]);
    c = ~c;
    exp_q.push_back(c[7:0]);
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[23:16]);
    exp_q.push_back(c[31:24]);
  endtask

  task automatic run_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                           input int n, input bit stall, input bit gaps,
                           input bit chained, input bit hold_after);
    int base_done, base_trunc, budget, idx, mism, lim;
    bit acc;
    logic [31:0] c;
    stall_en   = stall;
    base_done  = done_n;
    base_trunc = trunc_n;
    stab_err   = 0;
    ifg_viol   = 0;
    build_exp(d, s, t, n);
    if (!chained) begin
      @(posedge clk);
      #1;
      start = 1'b1;
    end
    dest_mac = d;
    src_mac  = s;
    eth_type = t;
    got.delete();
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    #1;
    check("first_preamble", 32'({tx_valid, tx_data}), 32'h155);
    check("busy_after_start", 32'(busy), 32'd1);
    if (chained) check("restart_gap", 32'(cyc - done_cyc), 32'd13);
    @(posedge clk);
    #1;
    idx = 0;
    budget = n * 6 + 200;
    while (idx < n && budget > 0) begin
      pl_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      pl_data  = pl_mem[idx];
      pl_last  = (idx == n - 1);
      @(negedge clk);
      acc = pl_valid && pl_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      budget--;
    end
    pl_valid = 1'b0;
    pl_last  = 1'b0;
    check("payload_consumed", 32'(idx), 32'(n));
    if (hold_after) start = 1'b1;
    budget = 300;
    while (done_n == base_done && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    check("done_pulses", 32'(done_n - base_done), 32'd1);
    budget = 40;
    while (busy && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    check("busy_dropped", 32'(busy), 32'd0);
    check("frame_len", 32'(got.size()), 32'(exp_q.size()));
    mism = 0;
    lim = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < lim; i++) if (got[i] !== exp_q[i]) mism++;
    check("byte_mismatches", 32'(mism), 32'd0);
    c = 32'hFFFF_FFFF;
    for (int i = 8; i < got.size(); i++) c = crc32_step(c, got[i]);
    check("crc_residue", c, 32'hDEBB20E3);
    check("done_index", 32'(done_idx), 32'(exp_q.size()));
    check("trunc_at_done", 32'(trunc_at_done), 32'(n > 1500));
    check("trunc_pulses", 32'(trunc_n - base_trunc), 32'(n > 1500));
    check("ifg_len", 32'(fall_cyc - done_cyc), 32'd12);
    check("ifg_idle", 32'(ifg_viol), 32'd0);
    if (stall) check("stall_hold", 32'(stab_err), 32'd0);
    stall_en = 0;
  endtask

  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC1  = 48'h0200_0000_0001;

  initial begin
    #12;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_busy_ready", 32'({busy, pl_ready, done, trunc_err}), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // minimum payload, then start held through FCS/IFG into a back-to-back frame
    for (int i = 0; i < 46; i++) pl_mem[i] = 8'(i);
    run_frame(BCAST, SRC1, 16'h0800, 46, 0, 0, 0, 1);
    pl_mem[0] = 8'hAB;
    run_frame(BCAST, SRC1, 16'h0800, 1, 0, 0, 1, 0);

    for (int i = 0; i < 100; i++) pl_mem[i] = 8'(i * 7 + 3);
    run_frame(48'h0A0B_0C0D_0E0F, SRC1, 16'h86DD, 100, 1, 1, 0, 0);

    for (int i = 0; i < 1502; i++) pl_mem[i] = 8'(i);
    run_frame(BCAST, SRC1, 16'h0800, 1502, 0, 0, 0, 0);

    // abandon a frame mid-payload
    @(posedge clk);
    #1;
    dest_mac = BCAST;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    pl_valid = 1'b1;
    pl_data = 8'h5A;
    repeat (30) @(posedge clk);
    #1;
    check("pre_reset_pl_ready", 32'({busy, pl_ready, tx_valid}), 32'h7);
    reset = 1'b1;
    #1;
    check("reset_tx_valid", 32'(tx_valid), 32'd0);
    check("reset_pl_ready", 32'(pl_ready), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    pl_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 60; i++) pl_mem[i] = 8'(255 - i);
    run_frame(48'h0011_2233_4455, SRC1, 16'h0806, 60, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
